id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register between decode/register-file read and the execute stage.
//  Captures operand data, immediate and control from decode, detects load-use hazards,
//  inserts bubbles, honours execute back-pressure and branch flush.
//  Counts bubble cycles for performance analysis.
// PARAMETERS
//  XLEN    32  datapath / operand width
//  CTRL_W  8   width of opaque ALU/branch control bundle passed through
//  CNT_W   16  width of saturating bubble counter
// PORTS
//  clk           in   1       clock, all state updates on posedge
//  rst_n         in   1       asynchronous active-low reset
//  id_valid      in   1       decode slot holds a real instruction
//  id_pc         in   XLEN    instruction PC
//  id_rs1        in   5       source register 1 index
//  id_rs2        in   5       source register 2 index
//  id_rd         in   5       destination register index
//  id_rs1_data   in   XLEN    register-file read data 1
//  id_rs2_data   in   XLEN    register-file read data 2
//  id_imm        in   XLEN    sign-extended immediate
//  id_ctrl       in   CTRL_W  pass-through control bundle
//  id_mem_read   in   1       instruction is a load
//  id_reg_write  in   1       instruction writes rd
//  flush_i       in   1       kill instructions in ID and EX (taken branch)
//  ex_stall_i    in   1       execute cannot accept; hold EX contents
//  wb_reg_write  in   1       writeback writing the register file this cycle
//  wb_rd         in   5       writeback destination index
//  wb_data       in   XLEN    writeback data
//  id_stall_o    out  1       combinational: fetch/decode must hold current instruction
//  ex_valid      out  1       EX slot valid
//  ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm, ex_ctrl,
//  ex_mem_read, ex_reg_write   out  (widths as id_*)  registered copies
//  bubble_cnt    out  CNT_W   saturating count of bubbles inserted
// BEHAVIOUR
//  Reset: every output register = 0 (ex_valid=0, bubble_cnt=0) immediately, async.
//  Latency: 1 cycle, id_* at posedge N appears on ex_* after posedge N.
//  load_use = ex_valid & ex_mem_read & ex_rd!=0 & id_valid &
//             (ex_rd==id_rs1 | ex_rd==id_rs2).
//  Per-cycle priority (highest first):
//   1 flush_i: ex_valid, ex_mem_read, ex_reg_write <= 0; data fields don't-care; no count.
//   2 ex_stall_i: hold all ex_* registers unchanged.
//   3 load_use: bubble, ex_valid/ex_mem_read/ex_reg_write <= 0; bubble_cnt += 1.
//   4 else: capture all id_*; ex_valid <= id_valid; ex_mem_read/ex_reg_write gated by id_valid.
//  id_stall_o = ~flush_i & (ex_stall_i | load_use).
//  Load-use stall lasts exactly 1 cycle (bubble clears ex_mem_read).
//  rd==0 never triggers a hazard; ex_reg_write forced 0 when id_rd==0.
//  bubble_cnt saturates at all-ones, no wrap.
//  Flush asserted with ex_stall_i: flush wins. Reset mid-stall: EX empties, stall drops.
// CONFIGURATION
//  WB_BYPASS_EN defined: on capture, if wb_reg_write & wb_rd!=0 & wb_rd==id_rsN,
//   ex_rsN_data <= wb_data instead of id_rsN_data. This covers the register-file
//   same-cycle write/read window.
//  Undefined: ex_rsN_data always <= id_rsN_data; wb_* ports present but ignored.
// STRUCTURE
//  Shared package: XLEN, CTRL_W, REG_X0 = 5'd0, idex_bundle_t struct of ex_* fields.
//  One sub-module: idex_hazard_unit (combinational load_use and id_stall_o).
//  Register bank and counter stay in top.
// TESTING
//  Reset: rst_n=0 mid-run -> all ex_*=0, bubble_cnt=0 without clock edge.
//  Pass-through: id_valid=1, rs1_data=0x12345678, imm=0xFFFFFFFC
//   -> same values on ex_* next cycle.
//  Load-use: EX lw x5, ID add x6,x5,x1
//   -> id_stall_o=1 one cycle, bubble (ex_valid=0), bubble_cnt=1, then add issues.
//  rd=x0 load followed by use of x0 -> no stall, bubble_cnt unchanged.
//  Flush+stall together: flush_i=1, ex_stall_i=1 -> ex_valid=0, id_stall_o=0.
//   Stall alone for 3 cycles -> ex_* held.
//  WB_BYPASS_EN: wb_rd=7, wb_data=0xCAFE0001, id_rs2=7, rs2_data=0
//   -> ex_rs2_data=0xCAFE0001. Without macro -> 0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register.
package id_ex_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned REG_W  = 5;

  localparam logic [REG_W-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
    logic              mem_read;
    logic              reg_write;
  } idex_bundle_t;

  // Selects the writeback value when it targets the register being read this cycle.
  function automatic logic [XLEN-1:0] wb_fwd(input logic             wb_we,
                                             input logic [REG_W-1:0] wb_rd,
                                             input logic [XLEN-1:0]  wb_data,
                                             input logic [REG_W-1:0] rs,
                                             input logic [XLEN-1:0]  rf_data);
    if (wb_we && (wb_rd != REG_X0) && (wb_rd == rs)) begin
      return wb_data;
    end
    return rf_data;
  endfunction

endpackage

// File: rtl/idex_hazard_unit.sv
// Combinational load-use detection and decode stall request for the ID/EX register.
module idex_hazard_unit
  import id_ex_stage_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             flush_i,
  input  logic             ex_stall_i,
  output logic             load_use,
  output logic             id_stall_o
);

  always_comb begin
    load_use = ex_valid & ex_mem_read & (ex_rd != REG_X0) & id_valid &
               ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    // A flush kills the decode slot, so there is nothing left to hold.
    id_stall_o = ~flush_i & (ex_stall_i | load_use);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, stall and bubble counter.
// Optional build macro WB_BYPASS_EN forwards same-cycle writeback data into the captured operands.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic              flush_i,
  input  logic              ex_stall_i,
  input  logic              wb_reg_write,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              id_stall_o,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_W-1:0]  ex_rs1,
  output logic [REG_W-1:0]  ex_rs2,
  output logic [REG_W-1:0]  ex_rd,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [CNT_W-1:0]  bubble_cnt
);

  idex_bundle_t       ex_q, ex_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               load_use;
  logic [XLEN-1:0]    rs1_val, rs2_val;

  idex_hazard_unit u_hazard (
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.mem_read),
    .ex_rd       (ex_q.rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .flush_i     (flush_i),
    .ex_stall_i  (ex_stall_i),
    .load_use    (load_use),
    .id_stall_o  (id_stall_o)
  );

`ifdef WB_BYPASS_EN
  assign rs1_val = wb_fwd(wb_reg_write, wb_rd, wb_data, id_rs1, id_rs1_data);
  assign rs2_val = wb_fwd(wb_reg_write, wb_rd, wb_data, id_rs2, id_rs2_data);
`else
  logic unused_wb;
  assign unused_wb = ^{wb_reg_write, wb_rd, wb_data};
  assign rs1_val   = id_rs1_data;
  assign rs2_val   = id_rs2_data;
`endif

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      ex_d.valid     = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.reg_write = 1'b0;
    end else if (ex_stall_i) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d.valid     = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.reg_write = 1'b0;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      ex_d.valid     = id_valid;
      ex_d.pc        = id_pc;
      ex_d.rs1       = id_rs1;
      ex_d.rs2       = id_rs2;
      ex_d.rd        = id_rd;
      ex_d.rs1_data  = rs1_val;
      ex_d.rs2_data  = rs2_val;
      ex_d.imm       = id_imm;
      ex_d.ctrl      = id_ctrl;
      ex_d.mem_read  = id_valid & id_mem_read;
      // Writes to x0 are architecturally void; drop them here so later stages need not check.
      ex_d.reg_write = id_valid & id_reg_write & (id_rd != REG_X0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_rs1_data  = ex_q.rs1_data;
  assign ex_rs2_data  = ex_q.rs2_data;
  assign ex_imm       = ex_q.imm;
  assign ex_ctrl      = ex_q.ctrl;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_reg_write = ex_q.reg_write;
  assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; counter narrowed to 2 bits to reach saturation.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [7:0]  id_ctrl;
  logic        id_mem_read, id_reg_write;
  logic        flush_i, ex_stall_i;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        id_stall_o, ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm;
  logic [7:0]  ex_ctrl;
  logic        ex_mem_read, ex_reg_write;
  logic [1:0]  bubble_cnt;

  int total = 0;
  int bad   = 0;

  id_ex_stage #(.CNT_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_rs1_data  (id_rs1_data),
    .id_rs2_data  (id_rs2_data),
    .id_imm       (id_imm),
    .id_ctrl      (id_ctrl),
    .id_mem_read  (id_mem_read),
    .id_reg_write (id_reg_write),
    .flush_i      (flush_i),
    .ex_stall_i   (ex_stall_i),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .id_stall_o   (id_stall_o),
    .ex_valid     (ex_valid),
    .ex_pc        (ex_pc),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rd        (ex_rd),
    .ex_rs1_data  (ex_rs1_data),
    .ex_rs2_data  (ex_rs2_data),
    .ex_imm       (ex_imm),
    .ex_ctrl      (ex_ctrl),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .bubble_cnt   (bubble_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic mr,
                        input logic rw);
    id_valid     = v;
    id_pc        = pc;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_mem_read  = mr;
    id_reg_write = rw;
  endtask

  initial begin
    logic [31:0] bypass_exp;
`ifdef WB_BYPASS_EN
    bypass_exp = 32'hCAFE0001;
`else
    bypass_exp = 32'h0;
`endif
    rst_n = 1'b0;
    set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_ctrl = '0;
    flush_i = 1'b0; ex_stall_i = 1'b0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    tick();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_cnt", {30'd0, bubble_cnt}, 32'd0);
    rst_n = 1'b1;

    // Plain pass-through
    set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
    id_rs1_data = 32'h12345678; id_rs2_data = 32'h9ABCDEF0;
    id_imm = 32'hFFFFFFFC; id_ctrl = 8'h5A;
    tick();
    chk("pt_valid", {31'd0, ex_valid}, 32'd1);
    chk("pt_pc", ex_pc, 32'h100);
    chk("pt_rs1_data", ex_rs1_data, 32'h12345678);
    chk("pt_rs2_data", ex_rs2_data, 32'h9ABCDEF0);
    chk("pt_imm", ex_imm, 32'hFFFFFFFC);
    chk("pt_ctrl", {24'd0, ex_ctrl}, 32'h5A);
    chk("pt_rd", {27'd0, ex_rd}, 32'd3);
    chk("pt_rw", {31'd0, ex_reg_write}, 32'd1);
    chk("pt_stall", {31'd0, id_stall_o}, 32'd0);

    // lw x5 then add x6,x5,x1
    set_id(1'b1, 32'h104, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1);
    tick();
    chk("lu_ex_mr", {31'd0, ex_mem_read}, 32'd1);
    set_id(1'b1, 32'h108, 5'd5, 5'd1, 5'd6, 1'b0, 1'b1);
    #1;
    chk("lu_stall_on", {31'd0, id_stall_o}, 32'd1);
    tick();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_mr", {31'd0, ex_mem_read}, 32'd0);
    chk("lu_cnt1", {30'd0, bubble_cnt}, 32'd1);
    chk("lu_stall_off", {31'd0, id_stall_o}, 32'd0);
    tick();
    chk("lu_issue_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_issue_pc", ex_pc, 32'h108);
    chk("lu_issue_rd", {27'd0, ex_rd}, 32'd6);

    // Load to x0 followed by a use of x0
    set_id(1'b1, 32'h10C, 5'd1, 5'd1, 5'd0, 1'b1, 1'b1);
    tick();
    chk("x0_rw_forced", {31'd0, ex_reg_write}, 32'd0);
    chk("x0_mr", {31'd0, ex_mem_read}, 32'd1);
    set_id(1'b1, 32'h110, 5'd0, 5'd0, 5'd7, 1'b0, 1'b1);
    #1;
    chk("x0_no_stall", {31'd0, id_stall_o}, 32'd0);
    tick();
    chk("x0_pc", ex_pc, 32'h110);
    chk("x0_cnt", {30'd0, bubble_cnt}, 32'd1);

    // Execute stall holds EX for three cycles
    ex_stall_i = 1'b1;
    set_id(1'b1, 32'h114, 5'd1, 5'd2, 5'd8, 1'b0, 1'b1);
    #1;
    chk("st_stall_o", {31'd0, id_stall_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold_pc", ex_pc, 32'h110);
      chk("st_hold_rd", {27'd0, ex_rd}, 32'd7);
    end

    // Flush wins over stall
    flush_i = 1'b1;
    #1;
    chk("fl_stall_o", {31'd0, id_stall_o}, 32'd0);
    tick();
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_rw", {31'd0, ex_reg_write}, 32'd0);
    chk("fl_cnt", {30'd0, bubble_cnt}, 32'd1);
    flush_i = 1'b0; ex_stall_i = 1'b0;

    // Writeback targets rs2 in the same cycle
    set_id(1'b1, 32'h200, 5'd3, 5'd7, 5'd9, 1'b0, 1'b1);
    id_rs1_data = 32'h33; id_rs2_data = 32'h0;
    wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 32'hCAFE0001;
    tick();
    chk("wb_rs2_data", ex_rs2_data, bypass_exp);
    chk("wb_rs1_data", ex_rs1_data, 32'h33);
    wb_reg_write = 1'b0;

    // Three more load-use bubbles saturate the 2-bit counter
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 32'h300, 5'd1, 5'd1, 5'd5, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 32'h304, 5'd5, 5'd1, 5'd6, 1'b0, 1'b1);
      tick();
      tick();
    end
    chk("sat_cnt", {30'd0, bubble_cnt}, 32'd3);

    // Reset during a load-use stall
    set_id(1'b1, 32'h400, 5'd1, 5'd1, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 32'h404, 5'd5, 5'd1, 5'd6, 1'b0, 1'b1);
    #1;
    chk("mr_stall_pre", {31'd0, id_stall_o}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'd0, ex_valid}, 32'd0);
    chk("mr_mr", {31'd0, ex_mem_read}, 32'd0);
    chk("mr_pc", ex_pc, 32'h0);
    chk("mr_cnt", {30'd0, bubble_cnt}, 32'd0);
    chk("mr_stall", {31'd0, id_stall_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
